// File: rtl/pht_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : pht_write_scheduler_pkg
// Brief  : Shared types, constants and helpers for the PHT write scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
package pht_write_scheduler_pkg;

  // Two-bit saturating counters; init value is weakly-taken.
  localparam int PHT_ENTRY_WIDTH = 2;
  localparam int PHT_ENTRY_MAX   = (1 << PHT_ENTRY_WIDTH) - 1;
  localparam int PHT_INIT_VALUE  = PHT_ENTRY_MAX / 2 + 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_write_sched_state_t;

  // Bank is the low log2(bank_num) bits of the index (bank_num is a power of two).
  function automatic int unsigned pht_bank(input int unsigned index,
                                           input int unsigned bank_num);
    return index & (bank_num - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pht_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : pht_write_scheduler_if
// Brief  : Request bus from the update logic and write bus to the PHT RAM.
// Rev    : 1.0 - initial release
// ============================================================================
interface pht_write_scheduler_if #(
  parameter int WRITE_NUM   = 2,
  parameter int INDEX_WIDTH = 11,
  parameter int ENTRY_WIDTH = 2
);
  logic [WRITE_NUM-1:0]             req_valid;
  logic [WRITE_NUM*INDEX_WIDTH-1:0] req_index;
  logic [WRITE_NUM*ENTRY_WIDTH-1:0] req_value;
  logic [WRITE_NUM-1:0]             ram_we;
  logic [WRITE_NUM*INDEX_WIDTH-1:0] ram_wa;
  logic [WRITE_NUM*ENTRY_WIDTH-1:0] ram_wv;

  // Requester side: issues counter updates, observes RAM writes.
  modport master (
    output req_valid, req_index, req_value,
    input  ram_we, ram_wa, ram_wv
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_index, req_value,
    output ram_we, ram_wa, ram_wv
  );
endinterface
`default_nettype wire

// File: rtl/pht_write_scheduler_conflict_fifo.sv
`default_nettype none
// ============================================================================
// Module : pht_conflict_fifo
// Brief  : Multi-push, single-pop circular buffer holding conflicting writes.
//          Valid push lanes are packed in lane order; the caller guarantees
//          there is room for every asserted lane.
// Rev    : 1.0 - initial release
// ============================================================================
module pht_conflict_fifo #(
  parameter  int DATA_WIDTH = 13,
  parameter  int DEPTH      = 4,
  parameter  int PUSH_NUM   = 1,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [PUSH_NUM-1:0]            push_valid,
  input  logic [PUSH_NUM*DATA_WIDTH-1:0] push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic [CNT_W-1:0]               count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      lane_addr [PUSH_NUM];
  logic [CNT_W-1:0]      push_cnt;

  // Each valid lane lands after all earlier valid lanes of the same cycle.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < PUSH_NUM; k++) begin
      lane_addr[k] = wr_ptr + push_cnt[PTR_W-1:0];
      if (push_valid[k]) push_cnt = push_cnt + CNT_W'(1);
    end
  end

  // Storage array; a flush discards same-cycle pushes via the pointer reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH_NUM; k++) begin
      if (push_valid[k] && !flush) mem[lane_addr[k]] <= push_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + push_cnt - CNT_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/pht_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module : pht_write_scheduler
// Brief  : Arbitrates PHT counter updates onto the banked RAM write ports,
//          buffers bank-conflict losers in an in-order FIFO, drains the head
//          into a free non-conflicting port, and runs the init sweep.
// Rev    : 1.0 - initial release
// ============================================================================
module pht_write_scheduler
  import pht_write_scheduler_pkg::*;
#(
  parameter  int WRITE_NUM   = 2,
  parameter  int ENTRY_NUM   = 2048,
  parameter  int INDEX_WIDTH = $clog2(ENTRY_NUM),
  parameter  int ENTRY_WIDTH = PHT_ENTRY_WIDTH,
  parameter  int BANK_NUM    = 2,
  parameter  int QUEUE_SIZE  = 4,
  parameter  int INIT_VALUE  = PHT_INIT_VALUE,
  localparam int CNT_W       = $clog2(QUEUE_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reinit_req,
  pht_write_scheduler_if.slave bus,
  output logic                 init_done,
  output logic [CNT_W-1:0]     queue_count,
  output logic [15:0]          drop_count
);

  localparam int DATA_W   = INDEX_WIDTH + ENTRY_WIDTH;
  localparam int PUSH_NUM = WRITE_NUM - 1;

  pht_write_sched_state_t           state;
  logic [INDEX_WIDTH-1:0]           init_idx;
  logic [WRITE_NUM-1:0]             grant;
  int unsigned                      req_bank [WRITE_NUM];
  logic [PUSH_NUM-1:0]              push_valid;
  logic [PUSH_NUM*DATA_W-1:0]       push_data;
  logic                             pop;
  logic                             flush;
  logic [DATA_W-1:0]                head_data;
  logic [15:0]                      drop_inc;
  logic [16:0]                      drop_sum;
  logic [WRITE_NUM-1:0]             we;
  logic [WRITE_NUM*INDEX_WIDTH-1:0] wa;
  logic [WRITE_NUM*ENTRY_WIDTH-1:0] wv;
  logic                             ok;
  logic                             blocked;
  int unsigned                      head_bank;
  int                               space;
  int                               pushed;

  assign flush = (state == ST_RUN) && reinit_req;

  for (genvar i = 0; i < WRITE_NUM; i++) begin : g_bank
    assign req_bank[i] = pht_bank(32'(bus.req_index[i*INDEX_WIDTH +: INDEX_WIDTH]), BANK_NUM);
  end

  // Same-cycle grant, loser push/drop and head drain onto the write ports.
  always_comb begin
    grant      = '0;
    push_valid = '0;
    push_data  = '0;
    drop_inc   = '0;
    pop        = 1'b0;
    we         = '0;
    wa         = '0;
    wv         = '0;
    ok         = 1'b0;
    blocked    = 1'b0;
    head_bank  = '0;
    space      = 0;
    pushed     = 0;
    if (state == ST_INIT) begin
      we[0]                 = ~rst;
      wa[INDEX_WIDTH-1:0]   = init_idx;
      wv[ENTRY_WIDTH-1:0]   = ENTRY_WIDTH'(INIT_VALUE);
    end else begin
      for (int i = 0; i < WRITE_NUM; i++) begin
        ok = bus.req_valid[i];
        for (int j = 0; j < i; j++) begin
          if (grant[j] && (req_bank[j] == req_bank[i])) ok = 1'b0;
        end
        grant[i] = ok;
        if (ok) begin
          we[i]                             = 1'b1;
          wa[i*INDEX_WIDTH +: INDEX_WIDTH]  = bus.req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
          wv[i*ENTRY_WIDTH +: ENTRY_WIDTH]  = bus.req_value[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
      end
      // Requester 0 always wins, so only requesters 1.. can lose; lane = i-1.
      // Capacity is judged on start-of-cycle occupancy.
      space = QUEUE_SIZE - int'(queue_count);
      for (int i = 1; i < WRITE_NUM; i++) begin
        if (bus.req_valid[i] && !grant[i]) begin
          if (pushed < space) begin
            push_valid[i-1]                   = 1'b1;
            push_data[(i-1)*DATA_W +: DATA_W] = {bus.req_index[i*INDEX_WIDTH +: INDEX_WIDTH],
                                                 bus.req_value[i*ENTRY_WIDTH +: ENTRY_WIDTH]};
            pushed                            = pushed + 1;
          end else begin
            drop_inc = drop_inc + 16'd1;
          end
        end
      end
      // Only the head may drain, and only if its bank is untouched this cycle.
      if (queue_count != '0) begin
        head_bank = pht_bank(32'(head_data[DATA_W-1:ENTRY_WIDTH]), BANK_NUM);
        for (int j = 0; j < WRITE_NUM; j++) begin
          if (grant[j] && (req_bank[j] == head_bank)) blocked = 1'b1;
        end
        if (!blocked) begin
          for (int p = 0; p < WRITE_NUM; p++) begin
            if (!grant[p] && !pop) begin
              pop                               = 1'b1;
              we[p]                             = 1'b1;
              wa[p*INDEX_WIDTH +: INDEX_WIDTH]  = head_data[DATA_W-1:ENTRY_WIDTH];
              wv[p*ENTRY_WIDTH +: ENTRY_WIDTH]  = head_data[ENTRY_WIDTH-1:0];
            end
          end
        end
      end
    end
  end

  assign bus.ram_we = we;
  assign bus.ram_wa = wa;
  assign bus.ram_wv = wv;

  // Init sweep / run state machine with registered init_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_idx  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + INDEX_WIDTH'(1);
          if (init_idx == INDEX_WIDTH'(ENTRY_NUM - 1)) begin
            state     <= ST_RUN;
            init_idx  <= '0;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (reinit_req) begin
            state     <= ST_INIT;
            init_idx  <= '0;
            init_done <= 1'b0;
          end
        end
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_count} + {1'b0, drop_inc};

  // Saturating count of requests lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              drop_count <= '0;
    else if (drop_sum[16]) drop_count <= 16'hFFFF;
    else                  drop_count <= drop_sum[15:0];
  end

  pht_conflict_fifo #(
    .DATA_WIDTH (DATA_W),
    .DEPTH      (QUEUE_SIZE),
    .PUSH_NUM   (PUSH_NUM)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head_data),
    .count      (queue_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_pht_write_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_pht_write_scheduler
// Brief  : Self-checking bench: init sweep, table vectors, reinit sequence
//          and a random phase against a pending-write scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pht_write_scheduler;

  localparam int WN = 2;
  localparam int EN = 16;
  localparam int IW = 4;
  localparam int EW = 2;
  localparam int BN = 2;
  localparam int QS = 4;
  localparam int IV = 2;
  localparam int NV = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        reinit_req;
  logic        init_done;
  logic [2:0]  queue_count;
  logic [15:0] drop_count;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [1:0]  v;
    logic [3:0]  i0;
    logic [1:0]  d0;
    logic [3:0]  i1;
    logic [1:0]  d1;
    logic [1:0]  we;
    logic [3:0]  a0;
    logic [1:0]  w0;
    logic [3:0]  a1;
    logic [1:0]  w1;
    logic [2:0]  qc;
    logic [15:0] drop;
  } vec_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [1:0] val;
  } wr_t;

  vec_t vecs [NV];
  wr_t  pending [$];

  pht_write_scheduler_if #(.WRITE_NUM(WN), .INDEX_WIDTH(IW), .ENTRY_WIDTH(EW)) bus ();

  pht_write_scheduler #(
    .WRITE_NUM(WN), .ENTRY_NUM(EN), .INDEX_WIDTH(IW), .ENTRY_WIDTH(EW),
    .BANK_NUM(BN), .QUEUE_SIZE(QS), .INIT_VALUE(IV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reinit_req  (reinit_req),
    .bus         (bus),
    .init_done   (init_done),
    .queue_count (queue_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input int i0, input int d0, input int i1, input int d1,
                              input logic [1:0] we, input int a0, input int w0, input int a1, input int w1,
                              input int qc, input int drop);
    vec_t r;
    r.v = v; r.i0 = 4'(i0); r.d0 = 2'(d0); r.i1 = 4'(i1); r.d1 = 2'(d1);
    r.we = we; r.a0 = 4'(a0); r.w0 = 2'(w0); r.a1 = 4'(a1); r.w1 = 2'(w1);
    r.qc = 3'(qc); r.drop = 16'(drop);
    return r;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [3:0] i0, input logic [1:0] d0,
                       input logic [3:0] i1, input logic [1:0] d1);
    bus.req_valid = v;
    bus.req_index = {i1, i0};
    bus.req_value = {d1, d0};
  endtask

  task automatic chk_init(input int k);
    chk($sformatf("init%0d_we", k), 32'(bus.ram_we), 32'(2'b01));
    chk($sformatf("init%0d_wa", k), 32'(bus.ram_wa[3:0]), 32'(k));
    chk($sformatf("init%0d_wv", k), 32'(bus.ram_wv[1:0]), 32'(IV));
    chk($sformatf("init%0d_done", k), 32'(init_done), 32'(0));
  endtask

  // Match each issued write against the pending set; banks must differ.
  task automatic sb_cycle();
    logic found;
    wr_t  w;
    for (int p = 0; p < WN; p++) begin
      if (bus.ram_we[p]) begin
        w.idx = bus.ram_wa[p*IW +: IW];
        w.val = bus.ram_wv[p*EW +: EW];
        found = 1'b0;
        for (int k = 0; k < pending.size(); k++) begin
          if (!found && pending[k] == w) begin
            pending.delete(k);
            found = 1'b1;
          end
        end
        chk($sformatf("sb_match_p%0d_idx%0d", p, w.idx), 32'(found), 32'(1));
      end
    end
    if (bus.ram_we == 2'b11)
      chk("sb_bank_distinct", 32'(bus.ram_wa[0] != bus.ram_wa[IW]), 32'(1));
    chk("sb_qc_range", 32'(queue_count <= 3'(QS)), 32'(1));
  endtask

  initial begin
    logic [1:0]  rv, rd0, rd1;
    logic [3:0]  ri0, ri1;
    logic [15:0] drop_base;
    wr_t         e;
    int          guard;

    vecs[0]  = mk(2'b11, 4,3, 7,1,  2'b11, 4,3, 7,1,  0,0);
    vecs[1]  = mk(2'b00, 0,0, 0,0,  2'b00, 0,0, 0,0,  0,0);
    vecs[2]  = mk(2'b11, 4,3, 6,0,  2'b01, 4,3, 0,0,  0,0);
    vecs[3]  = mk(2'b00, 0,0, 0,0,  2'b01, 6,0, 0,0,  1,0);
    vecs[4]  = mk(2'b00, 0,0, 0,0,  2'b00, 0,0, 0,0,  0,0);
    vecs[5]  = mk(2'b11, 0,1, 2,3,  2'b01, 0,1, 0,0,  0,0);
    vecs[6]  = mk(2'b11, 0,1, 2,3,  2'b01, 0,1, 0,0,  1,0);
    vecs[7]  = mk(2'b11, 0,1, 2,3,  2'b01, 0,1, 0,0,  2,0);
    vecs[8]  = mk(2'b11, 0,1, 2,3,  2'b01, 0,1, 0,0,  3,0);
    vecs[9]  = mk(2'b11, 0,1, 2,3,  2'b01, 0,1, 0,0,  4,0);
    vecs[10] = mk(2'b00, 0,0, 0,0,  2'b01, 2,3, 0,0,  4,1);
    vecs[11] = mk(2'b00, 0,0, 0,0,  2'b01, 2,3, 0,0,  3,1);
    vecs[12] = mk(2'b00, 0,0, 0,0,  2'b01, 2,3, 0,0,  2,1);
    vecs[13] = mk(2'b00, 0,0, 0,0,  2'b01, 2,3, 0,0,  1,1);
    vecs[14] = mk(2'b00, 0,0, 0,0,  2'b00, 0,0, 0,0,  0,1);
    vecs[15] = mk(2'b11, 4,3, 6,2,  2'b01, 4,3, 0,0,  0,1);
    vecs[16] = mk(2'b01, 3,1, 0,0,  2'b11, 3,1, 6,2,  1,1);
    vecs[17] = mk(2'b00, 0,0, 0,0,  2'b00, 0,0, 0,0,  0,1);
    vecs[18] = mk(2'b11, 8,1, 10,2, 2'b01, 8,1, 0,0,  0,1);
    vecs[19] = mk(2'b10, 0,0, 5,3,  2'b11, 10,2, 5,3, 1,1);
    vecs[20] = mk(2'b00, 0,0, 0,0,  2'b00, 0,0, 0,0,  0,1);
    vecs[21] = mk(2'b11, 1,0, 3,1,  2'b01, 1,0, 0,0,  0,1);
    vecs[22] = mk(2'b01, 5,2, 0,0,  2'b01, 5,2, 0,0,  1,1);
    vecs[23] = mk(2'b00, 0,0, 0,0,  2'b01, 3,1, 0,0,  1,1);
    vecs[24] = mk(2'b00, 0,0, 0,0,  2'b00, 0,0, 0,0,  0,1);

    // Reset with requests already held; they must be ignored through init.
    rst = 1'b1;
    reinit_req = 1'b0;
    drive(2'b11, 4'd1, 2'd3, 4'd3, 2'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", 32'(bus.ram_we), 32'(0));
    chk("rst_done", 32'(init_done), 32'(0));
    chk("rst_qc", 32'(queue_count), 32'(0));
    chk("rst_drop", 32'(drop_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < EN; k++) begin
      #1;
      chk_init(k);
      @(negedge clk);
    end
    drive(2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
    #1;
    chk("run_done", 32'(init_done), 32'(1));
    chk("run_drop", 32'(drop_count), 32'(0));
    chk("run_qc", 32'(queue_count), 32'(0));
    chk("run_idle_we", 32'(bus.ram_we), 32'(0));
    @(negedge clk);

    // Table-driven single-cycle vectors.
    for (int n = 0; n < NV; n++) begin
      drive(vecs[n].v, vecs[n].i0, vecs[n].d0, vecs[n].i1, vecs[n].d1);
      #1;
      chk($sformatf("v%0d_we", n), 32'(bus.ram_we), 32'(vecs[n].we));
      if (vecs[n].we[0]) begin
        chk($sformatf("v%0d_wa0", n), 32'(bus.ram_wa[3:0]), 32'(vecs[n].a0));
        chk($sformatf("v%0d_wv0", n), 32'(bus.ram_wv[1:0]), 32'(vecs[n].w0));
      end
      if (vecs[n].we[1]) begin
        chk($sformatf("v%0d_wa1", n), 32'(bus.ram_wa[7:4]), 32'(vecs[n].a1));
        chk($sformatf("v%0d_wv1", n), 32'(bus.ram_wv[3:2]), 32'(vecs[n].w1));
      end
      chk($sformatf("v%0d_qc", n), 32'(queue_count), 32'(vecs[n].qc));
      chk($sformatf("v%0d_drop", n), 32'(drop_count), 32'(vecs[n].drop));
      @(negedge clk);
    end

    // Fill the FIFO to 3, then reinit: drain still writes, then flush + sweep.
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 4'd0, 2'd1, 4'd2, 2'd1);
      #1;
      chk($sformatf("fill%0d_qc", c), 32'(queue_count), 32'(c));
      @(negedge clk);
    end
    drive(2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
    reinit_req = 1'b1;
    #1;
    chk("reinit_qc_before", 32'(queue_count), 32'(3));
    chk("reinit_drain_we", 32'(bus.ram_we), 32'(2'b01));
    chk("reinit_drain_wa", 32'(bus.ram_wa[3:0]), 32'(2));
    @(negedge clk);
    reinit_req = 1'b0;
    #1;
    chk("reinit_qc_after", 32'(queue_count), 32'(0));
    for (int k = 0; k < EN; k++) begin
      if (k != 0) #1;
      chk_init(k);
      @(negedge clk);
    end
    #1;
    chk("reinit_done", 32'(init_done), 32'(1));
    chk("reinit_drop_kept", 32'(drop_count), 32'(1));
    @(negedge clk);

    // Random traffic against the pending-write scoreboard.
    drop_base = drop_count;
    for (int c = 0; c < 300; c++) begin
      rv  = 2'($urandom_range(0, 3));
      ri0 = 4'($urandom_range(0, 15));
      ri1 = 4'($urandom_range(0, 15));
      rd0 = 2'($urandom_range(0, 3));
      rd1 = 2'($urandom_range(0, 3));
      drive(rv, ri0, rd0, ri1, rd1);
      if (rv[0]) begin e.idx = ri0; e.val = rd0; pending.push_back(e); end
      if (rv[1]) begin e.idx = ri1; e.val = rd1; pending.push_back(e); end
      #1;
      sb_cycle();
      @(negedge clk);
    end
    drive(2'b00, 4'd0, 2'd0, 4'd0, 2'd0);
    guard = 0;
    while (queue_count != 3'd0 && guard < 20) begin
      #1;
      sb_cycle();
      @(negedge clk);
      guard++;
    end
    #1;
    chk("rand_drain_empty", 32'(queue_count), 32'(0));
    chk("rand_leftover_eq_drops", 32'(pending.size()), 32'(drop_count - drop_base));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
